// File: rtl/ahb_arb_pkg.sv
// Shared AHB-Lite encodings and small helpers for the burst/lock-aware arbiter.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  // Beats still to come after the NONSEQ of a defined-length burst.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    logic [3:0] beats;
    case (hburst)
      HBURST_WRAP4, HBURST_INCR4:   beats = 4'd3;
      HBURST_WRAP8, HBURST_INCR8:   beats = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
      default:                      beats = 4'd0;
    endcase
    return beats;
  endfunction

  function automatic logic [4:0] onehot2bin(input logic [31:0] onehot);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (onehot[i]) begin
        idx = idx | 5'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_arb_rr_pick.sv
// Round-robin picker: first set candidate bit at or after i_start, wrapping.
module ahb_arb_rr_pick #(
  parameter int REQ_NUM = 4,
  parameter int SW      = 2
) (
  input  logic [REQ_NUM-1:0] i_cand,
  input  logic [SW-1:0]      i_start,
  output logic [REQ_NUM-1:0] o_pick
);

  always_comb begin
    logic          w_found;
    logic [SW-1:0] w_idx;
    o_pick  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      w_idx = SW'((int'(i_start) + k) % REQ_NUM);
      if (!w_found && i_cand[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        w_found       = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/ahb_burst_arbiter.sv
// AHB-Lite master arbiter: holds ownership across bursts, INCR runs and locked
// sequences; otherwise priority + round-robin with age promotion.
module ahb_burst_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int REQ_NUM   = 4,
  parameter int PRI_WIDTH = 2,
  parameter int DEF_MST   = 0,
  parameter int AGE_MAX   = 15,
  parameter int SW        = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
  parameter int AW        = $clog2(AGE_MAX + 1)
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [2*REQ_NUM-1:0]           m_htrans,
  input  logic [3*REQ_NUM-1:0]           m_hburst,
  input  logic [REQ_NUM-1:0]             m_hmastlock,
  input  logic [PRI_WIDTH*REQ_NUM-1:0]   pri,
  input  logic                           hready,
  output logic [REQ_NUM-1:0]             gnt,
  output logic [REQ_NUM-1:0]             last_gnt,
  output logic [SW-1:0]                  sel_a,
  output logic [SW-1:0]                  sel_d,
  output logic                           hold
);

  localparam logic [REQ_NUM-1:0] DEF_OH    = REQ_NUM'(1) << DEF_MST;
  localparam logic [SW-1:0]      DEF_IDX   = SW'(DEF_MST);
  localparam logic [AW-1:0]      AGE_MAX_V = AW'(AGE_MAX);

  logic [REQ_NUM-1:0]   r_gnt;
  logic [REQ_NUM-1:0]   r_last_gnt;
  logic [SW-1:0]        r_sel_a;
  logic [SW-1:0]        r_sel_d;
  logic [3:0]           r_beats_left;
  logic [AW-1:0]        r_age [REQ_NUM];

  logic [1:0]           w_trans [REQ_NUM];
  logic [2:0]           w_burst [REQ_NUM];
  logic [PRI_WIDTH-1:0] w_pri   [REQ_NUM];
  logic [REQ_NUM-1:0]   w_req;
  logic [1:0]           w_o_trans;
  logic [3:0]           w_beats_next;
  logic                 w_hold;
  logic [REQ_NUM-1:0]   w_aged;
  logic [REQ_NUM-1:0]   w_top;
  logic [PRI_WIDTH-1:0] w_maxpri;
  logic [REQ_NUM-1:0]   w_cand;
  logic [SW-1:0]        w_start;
  logic [REQ_NUM-1:0]   w_pick;
  logic [REQ_NUM-1:0]   w_next_gnt;

  always_comb begin
    for (int i = 0; i < REQ_NUM; i++) begin
      w_trans[i] = m_htrans[2*i +: 2];
      w_burst[i] = m_hburst[3*i +: 3];
      w_pri[i]   = pri[PRI_WIDTH*i +: PRI_WIDTH];
      w_req[i]   = (m_htrans[2*i +: 2] != HTRANS_IDLE);
    end
  end

  // Burst beat tracking and ownership hold for the current address-phase owner.
  always_comb begin
    w_o_trans = w_trans[r_sel_a];
    case (w_o_trans)
      HTRANS_NONSEQ: w_beats_next = burst_beats(w_burst[r_sel_a]);
      HTRANS_SEQ:    w_beats_next = (r_beats_left != 4'd0) ? (r_beats_left - 4'd1) : 4'd0;
      HTRANS_BUSY:   w_beats_next = r_beats_left;
      default:       w_beats_next = 4'd0;
    endcase
    // SEQ/BUSY outside a counted burst means an undefined-length INCR is still running.
    w_hold = (w_beats_next != 4'd0)
           | (((w_o_trans == HTRANS_SEQ) || (w_o_trans == HTRANS_BUSY)) && (r_beats_left == 4'd0))
           | (m_hmastlock[r_sel_a] & w_req[r_sel_a]);
  end

  always_comb begin
    w_maxpri = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (w_req[i] && (w_pri[i] > w_maxpri)) begin
        w_maxpri = w_pri[i];
      end else begin
        w_maxpri = w_maxpri;
      end
    end
    for (int i = 0; i < REQ_NUM; i++) begin
      w_aged[i] = w_req[i] && (r_age[i] == AGE_MAX_V);
      w_top[i]  = w_req[i] && (w_pri[i] == w_maxpri);
    end
    w_cand  = (|w_aged) ? w_aged : w_top;
    w_start = (r_sel_a == SW'(REQ_NUM - 1)) ? '0 : (r_sel_a + SW'(1));
  end

  ahb_arb_rr_pick #(
    .REQ_NUM (REQ_NUM),
    .SW      (SW)
  ) u_rr_pick (
    .i_cand  (w_cand),
    .i_start (w_start),
    .o_pick  (w_pick)
  );

  always_comb begin
    if (w_hold || (w_req == '0)) begin
      w_next_gnt = r_gnt;
    end else begin
      w_next_gnt = w_pick;
    end
  end

  // Grant pipeline, beat counter and ages advance only on accepted transfers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_gnt        <= DEF_OH;
      r_last_gnt   <= DEF_OH;
      r_sel_a      <= DEF_IDX;
      r_sel_d      <= DEF_IDX;
      r_beats_left <= 4'd0;
      for (int i = 0; i < REQ_NUM; i++) begin
        r_age[i] <= '0;
      end
    end else if (hready) begin
      r_last_gnt   <= r_gnt;
      r_sel_d      <= r_sel_a;
      r_gnt        <= w_next_gnt;
      r_sel_a      <= SW'(onehot2bin(32'(w_next_gnt)));
      r_beats_left <= w_beats_next;
      for (int i = 0; i < REQ_NUM; i++) begin
        if (w_req[i] && !w_next_gnt[i]) begin
          r_age[i] <= (r_age[i] == AGE_MAX_V) ? r_age[i] : (r_age[i] + AW'(1));
        end else begin
          r_age[i] <= '0;
        end
      end
    end
  end

  assign gnt      = r_gnt;
  assign last_gnt = r_last_gnt;
  assign sel_a    = r_sel_a;
  assign sel_d    = r_sel_d;
  assign hold     = w_hold;

endmodule
